// File: rtl/fft32_pkg.sv
// rtl/fft32_pkg.sv - shared constants, complex sample type and write-address map
// FFT32_DIGIT_REV_EN selects radix-(4,4,2) digit reversal; otherwise 5-bit bit reversal.
package fft32_pkg;

  localparam int FFT_N    = 32;
  localparam int FFT_LOGN = 5;
  localparam int DW       = 16;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  function automatic logic [FFT_LOGN-1:0] fft32_map(input logic [FFT_LOGN-1:0] w);
`ifdef FFT32_DIGIT_REV_EN
    return {w[0], w[2:1], w[4:3]};
`else
    return {w[0], w[1], w[2], w[3], w[4]};
`endif
  endfunction

endpackage

// File: rtl/fft32_pingpong_ram.sv
// rtl/fft32_pingpong_ram.sv - two 32-entry complex banks, one write port, one combinational read port
module fft32_pingpong_ram
  import fft32_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic                wr_bank,
  input  logic [FFT_LOGN-1:0] wr_addr,
  input  cplx_t               wr_data,
  input  logic                rd_bank,
  input  logic [FFT_LOGN-1:0] rd_addr,
  output cplx_t               rd_data
);

  cplx_t mem_q [2][FFT_N];
  cplx_t mem_d [2][FFT_N];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_bank][wr_addr] = wr_data;
    end
  end

  // Contents are only observable once a bank is marked full, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/fft32_out_reorder.sv
// rtl/fft32_out_reorder.sv - ping-pong reorder from FFT core order to natural bin order
// Address map chosen by FFT32_DIGIT_REV_EN (see fft32_pkg).
module fft32_out_reorder
  import fft32_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic [4:0]    out_idx,
  output logic          out_last,
  output logic          ovf,
  output logic          frm_err
);

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [4:0] wr_cnt_q, wr_cnt_d;
  logic [4:0] rd_cnt_q, rd_cnt_d;
  logic       ovf_q, ovf_d;
  logic       frm_err_q, frm_err_d;

  logic  wr_acc;
  logic  rd_acc;
  cplx_t rd_data;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_acc    = in_valid && in_ready;
  assign rd_acc    = out_valid && out_ready;

  fft32_pingpong_ram u_ram (
    .clk     (clk),
    .we      (wr_acc),
    .wr_bank (wr_bank_q),
    .wr_addr (fft32_map(wr_cnt_q)),
    .wr_data ({in_re, in_im}),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_cnt_q),
    .rd_data (rd_data)
  );

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    ovf_d     = ovf_q;
    frm_err_d = frm_err_q;

    if (in_valid && !in_ready) begin
      ovf_d = 1'b1;
    end

    if (wr_acc) begin
      if (wr_cnt_q == 5'd31) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_cnt_d          = 5'd0;
        if (!in_last) begin
          frm_err_d = 1'b1;
        end
      end else if (in_last) begin
        // Short frame: drop it and restart the same bank from address 0.
        frm_err_d = 1'b1;
        wr_cnt_d  = 5'd0;
      end else begin
        wr_cnt_d = wr_cnt_q + 5'd1;
      end
    end

    // A commit and a release in the same cycle always hit different banks.
    if (rd_acc) begin
      if (rd_cnt_q == 5'd31) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_cnt_d          = 5'd0;
      end else begin
        rd_cnt_d = rd_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= 5'd0;
      rd_cnt_q  <= 5'd0;
      ovf_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      ovf_q     <= ovf_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign out_re   = out_valid ? rd_data.re : '0;
  assign out_im   = out_valid ? rd_data.im : '0;
  assign out_idx  = rd_cnt_q;
  assign out_last = out_valid && (rd_cnt_q == 5'd31);
  assign ovf      = ovf_q;
  assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_fft32_out_reorder.sv
// tb/tb_fft32_out_reorder.sv - directed self-checking bench for fft32_out_reorder
module tb_fft32_out_reorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        ovf;
  logic        frm_err;

  fft32_out_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .ovf       (ovf),
    .frm_err   (frm_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [4:0]  idx;
  } exp_t;

  exp_t        eq[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] cap_re [32];
  logic        cap_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [15:0] hold_re, hold_im;
  logic [4:0]  hold_idx;
  logic        rand_done;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int inv_map(input int k);
    logic [4:0] kk;
    logic [4:0] w;
    kk = k[4:0];
`ifdef FFT32_DIGIT_REV_EN
    w = {kk[1:0], kk[3:2], kk[4]};
`else
    for (int i = 0; i < 5; i++) w[i] = kk[4-i];
`endif
    return int'(w);
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input int base);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.re  = 16'(base + inv_map(k));
      e.im  = -16'(base + inv_map(k));
      e.idx = 5'(k);
      eq.push_back(e);
    end
  endtask

  task automatic send_bin(input int v, input logic last);
    int t;
    in_valid = 1'b1;
    in_re    = 16'(v);
    in_im    = -16'(v);
    in_last  = last;
    t = 0;
    while (!in_ready && t < 400) begin
      tick;
      t++;
    end
    if (t == 400) chk("in_ready_timeout", 0, 1);
    tick;
  endtask

  task automatic send_frame(input int base, input logic commit);
    if (commit) push_frame(base);
    for (int w = 0; w < 32; w++) send_bin(base + w, w == 31);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain;
    int t;
    t = 0;
    while (eq.size() != 0 && t < 3000) begin
      tick;
      t++;
    end
    if (t == 3000) chk("drain_timeout", eq.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"},  32'(out_last),  0);
    chk({tag, "_out_idx"},   32'(out_idx),   0);
    chk({tag, "_out_re"},    32'(out_re),    0);
    chk({tag, "_out_im"},    32'(out_im),    0);
    chk({tag, "_ovf"},       32'(ovf),       0);
    chk({tag, "_frm_err"},   32'(frm_err),   0);
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_re",  32'(out_re),  32'(hold_re));
        chk("hold_im",  32'(out_im),  32'(hold_im));
        chk("hold_idx", 32'(out_idx), 32'(hold_idx));
      end
      if (out_valid && out_ready) begin
        if (eq.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = eq.pop_front();
          chk("out_re",   32'(out_re),   32'(e.re));
          chk("out_im",   32'(out_im),   32'(e.im));
          chk("out_idx",  32'(out_idx),  32'(e.idx));
          chk("out_last", 32'(out_last), (e.idx == 5'd31) ? 1 : 0);
          if (cap_en) cap_re[out_idx] = out_re;
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_re    = out_re;
      hold_im    = out_im;
      hold_idx   = out_idx;
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick;
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick;

    // Single frame in_re=w, in_im=-w; latency and natural ordering.
    out_ready = 1'b1;
    cap_en    = 1'b1;
    push_frame(0);
    for (int w = 0; w < 32; w++) begin
      send_bin(w, w == 31);
      if (w == 30) chk("valid_before_commit", 32'(out_valid), 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("valid_after_commit", 32'(out_valid), 1);
    chk("first_idx", 32'(out_idx), 0);
    wait_drain;
    cap_en = 1'b0;
`ifdef FFT32_DIGIT_REV_EN
    chk("k1_src", 32'(cap_re[1]), 8);
    chk("k3_src", 32'(cap_re[3]), 24);
`else
    chk("k1_src", 32'(cap_re[1]), 16);
    chk("k3_src", 32'(cap_re[3]), 24);
`endif
    chk("k31_src", 32'(cap_re[31]), 31);

    // Three frames with the sink stalled: both banks fill, third waits.
    chk("ovf_pre", 32'(ovf), 0);
    fork
      begin
        send_frame(1000, 1'b1);
        send_frame(2000, 1'b1);
        send_frame(3000, 1'b1);
      end
      begin
        out_ready = 1'b0;
        repeat (68) tick;
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_ovf", 32'(ovf), 1);
        chk("stall_out_valid", 32'(out_valid), 1);
        repeat (2) tick;
        out_ready = 1'b1;
        repeat (31) tick;
        chk("release_in_ready_lo", 32'(in_ready), 0);
        tick;
        chk("release_in_ready_hi", 32'(in_ready), 1);
      end
    join
    wait_drain;

    // Random sink backpressure over four frames.
    rand_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 4; f++) send_frame(4000 + 100 * f, 1'b1);
        rand_done = 1'b1;
      end
      begin
        int t;
        t = 0;
        while (!rand_done && t < 5000) begin
          out_ready = 1'($urandom_range(0, 1));
          tick;
          t++;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain;

    // Short frame: in_last at wr_cnt 10 is discarded.
    chk("frm_err_pre", 32'(frm_err), 0);
    for (int w = 0; w < 11; w++) send_bin(7 + w, w == 10);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick;
    chk("frm_err_set", 32'(frm_err), 1);
    repeat (40) tick;
    chk("short_no_valid", 32'(out_valid), 0);
    send_frame(5000, 1'b1);
    wait_drain;

    // Asynchronous reset mid-write at count 17.
    for (int w = 0; w < 17; w++) send_bin(600 + w, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_midwrite");
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Asynchronous reset mid-drain.
    out_ready = 1'b0;
    send_frame(6000, 1'b1);
    repeat (3) tick;
    out_ready = 1'b1;
    repeat (5) tick;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_middrain");
    eq.delete();
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst2_in_ready", 32'(in_ready), 1);
    chk("post_rst2_out_valid", 32'(out_valid), 0);

    send_frame(7000, 1'b1);
    wait_drain;
    chk("final_queue_empty", eq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fft32_out_reorder.md
# fft32_out_reorder

Output reorder stage directly downstream of the 32-point radix-4 DIF FFT core. Accepts one complex bin per cycle in the core's scrambled order, stores each 32-bin frame in a ping-pong buffer, and streams frames out in natural bin order (0..31) over a valid/ready handshake. Lets the FFT core write frame n+1 while frame n is drained.

## Interface
- DW, 16, width of each real/imag component (two's complement)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input bin valid
- in_ready  out  1  stage can accept a bin this cycle
- in_re  in  DW  input real part
- in_im  in  DW  input imag part
- in_last  in  1  marks the 32nd bin of a frame
- out_valid  out  1  output bin valid
- out_ready  in  1  downstream accepts bin
- out_re  out  DW  output real part
- out_im  out  DW  output imag part
- out_idx  out  5  natural bin index of current output
- out_last  out  1  high with bin 31
- ovf  out  1  sticky: in_valid seen while in_ready low
- frm_err  out  1  sticky: in_last/count mismatch

## Operation
- Two banks, 32 entries each, {re,im}; per-bank full flag; wr_bank, rd_bank pointers; 5-bit wr_cnt, rd_cnt.
- Write accept = in_valid & in_ready; in_ready = !full[wr_bank].
- On accept: store at addr = map(wr_cnt) in wr_bank; wr_cnt++. At wr_cnt==31: set full[wr_bank], toggle wr_bank, wr_cnt<=0.
- in_last on accept with wr_cnt!=31: set frm_err, discard partial frame (wr_cnt<=0, bank stays empty). wr_cnt==31 without in_last: set frm_err, frame still committed.
- Read: out_valid = full[rd_bank]; out_re/out_im = bank[rd_bank][rd_cnt] (flop array, combinational read); out_idx = rd_cnt; out_last = out_valid & (rd_cnt==31).
- On out_valid & out_ready: rd_cnt++; at 31 clear full[rd_bank], toggle rd_bank, rd_cnt<=0.
- ovf set on in_valid & !in_ready; the bin is dropped. ovf/frm_err clear only by reset.
- No arithmetic on data; values pass bit-exact.

## Timing
- Reset: in_ready=1, out_valid=0, out_last=0, out_idx=0, out_re=out_im=0 (bank contents need no reset, but outputs gated to 0 while !out_valid), ovf=0, frm_err=0, both banks empty, pointers 0.
- Latency: out_valid rises the cycle after the 32nd bin is accepted; minimum 33 cycles first-in to first-out.
- Throughput: 1 bin/cycle sustained with out_ready held high; no bubbles between frames.
- Same-cycle frame commit on write side and frame release on read side: both flag updates apply; set and clear target different banks by construction.
- Both banks full: in_ready low until the first read-side release cycle; in_ready high the following cycle.
- out_re/out_im/out_idx held stable while out_valid & !out_ready.
- rst mid-frame: all frames discarded, state as reset, asynchronously.

## Configuration
- FFT32_DIGIT_REV_EN defined: map(w) is mixed-radix (4,4,2) digit reversal: k[4]=w[0], k[3:2]=w[2:1], k[1:0]=w[4:3].
- Undefined: map(w) is 5-bit bit reversal, k[i]=w[4-i] (for radix-2 core builds).

## Structure
- Shared package fft32_pkg: FFT_N=32, FFT_LOGN=5, complex sample typedef {re,im} of DW, map function per macro.
- One sub-module: fft32_pingpong_ram (two banks, one write port, one combinational read port, bank select inputs).

## Test plan
- Frame of bins with in_re=w (write order), in_im=-w, out_ready=1, macro defined -> outputs in order k=0..31 with in_re = inverse map(k); e.g. k=1 gives in_re=8; out_last on k=31.
- Same with macro undefined -> k=1 gives in_re=16, k=3 gives in_re=24.
- Three back-to-back frames, out_ready=0 for 70 cycles -> in_ready drops after bin 64 accepted, ovf=1 if in_valid held, frames 1-2 output intact after release.
- in_last at wr_cnt=10 -> frm_err=1, no out_valid for that frame, next full frame outputs correctly.
- Random out_ready toggling over 4 frames -> outputs match model, no loss/duplication, data stable during stalls.
- rst asserted at write count 17 and mid-drain -> all outputs at reset values immediately, in_ready=1 one cycle after release.
